// File: rtl/hola_sweep_pkg.sv
// Shared types and sizes for the hola sweep self-test controller.
package hola_sweep_pkg;

  localparam int unsigned N_VEC = 16;
  localparam int unsigned VEC_W = 4;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [VEC_W-1:0] first_fail;
  } sweep_res_t;

  // Error counter increment that sticks at N_VEC.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(N_VEC)) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hola_sweep_ctrl_if.sv
// Control, circuit and result signals between the sweep controller and its user.
interface hola_sweep_ctrl_if;
  import hola_sweep_pkg::*;

  logic             start;
  logic             abort;
  logic             dut_s;
  logic [VEC_W-1:0] dut_vec;
  logic             busy;
  logic             done;
  sweep_res_t       res;

  modport master (
    output start, abort, dut_s,
    input  dut_vec, busy, done, res
  );

  modport slave (
    input  start, abort, dut_s,
    output dut_vec, busy, done, res
  );

endinterface

// File: rtl/hola_settle_cnt.sv
// Settle timer: loads SETTLE-1, counts down to zero, flags zero combinationally.
module hola_settle_cnt #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_c_o
);

  localparam int unsigned   CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/hola_sweep_ctrl.sv
// Self-test sequencer sweeping all 16 {a,b,c,d} vectors and checking s1 against EXP_TT.
// HOLA_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module hola_sweep_ctrl
  import hola_sweep_pkg::*;
#(
  parameter int unsigned      SETTLE = 1,
  parameter logic [N_VEC-1:0] EXP_TT = 16'hA8A8
) (
  input  logic             clk,
  input  logic             rst_n,
  hola_sweep_ctrl_if.slave bus
);

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(N_VEC - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] ff_q, ff_d;
  logic             load_c, dec_c, settle_zero_c, mismatch_c;

  hola_settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_c),
    .dec_i    (dec_c),
    .zero_c_o (settle_zero_c)
  );

  assign mismatch_c = (bus.dut_s != EXP_TT[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; abort overrides everything, including a same-cycle start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = DRIVE;
      DRIVE:      if (settle_zero_c) state_d = SAMPLE;
      SAMPLE: begin
`ifdef HOLA_SWEEP_STOP_ON_FAIL_EN
        if ((idx_q == LAST_IDX) || mismatch_c) state_d = DONE;
`else
        if (idx_q == LAST_IDX) state_d = DONE;
`endif
        else state_d = DRIVE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // Datapath and registered-output next values.
  always_comb begin
    idx_d  = idx_q;
    vec_d  = vec_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
    ff_d   = ff_q;
    load_c = 1'b0;
    dec_c  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_d == DRIVE) begin
          idx_d  = '0;
          vec_d  = '0;
          err_d  = '0;
          ff_d   = '0;
          done_d = 1'b0;
          busy_d = 1'b1;
          load_c = 1'b1;
        end
      end
      DRIVE: dec_c = ~settle_zero_c;
      SAMPLE: begin
        if (mismatch_c) begin
          err_d = sat_inc(err_q);
          if (err_q == '0) ff_d = idx_q;
        end
        if (state_d == DONE) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (state_d == DRIVE) begin
          idx_d  = idx_q + VEC_W'(1);
          vec_d  = idx_q + VEC_W'(1);
          load_c = 1'b1;
        end
      end
      default: ;
    endcase
    // Abort keeps the partial results but parks the circuit inputs at zero.
    if (bus.abort) begin
      busy_d = 1'b0;
      done_d = 1'b0;
      vec_d  = '0;
      err_d  = err_q;
      ff_d   = ff_q;
      load_c = 1'b0;
      dec_c  = 1'b0;
    end
  end

  assign pass_d = done_d && (err_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      vec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      ff_q   <= '0;
    end else begin
      idx_q  <= idx_d;
      vec_q  <= vec_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      ff_q   <= ff_d;
    end
  end

  assign bus.dut_vec        = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.res.pass       = pass_q;
  assign bus.res.err_cnt    = err_q;
  assign bus.res.first_fail = ff_q;

endmodule
